// File: rtl/elbeth_fetch_unit_pkg.sv
// Shared constants and types for the elbeth instruction fetch stage.
package elbeth_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/elbeth_fetch_buffer.sv
// Synchronous FIFO with sync clear; push while full is accepted only alongside a pop.
module elbeth_fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/elbeth_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads, buffers the
// responses and presents {pc, instruction} to decode; flushes on ID redirects.
module elbeth_fetch_unit
  import elbeth_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        fetch_misalign
);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, pcq_head;
  logic [CW-1:0] outstanding, discard, discard_nxt, discard_set, fifo_count;
  logic [CW:0]   occupancy;
  logic          pcq_full, pcq_empty, fifo_full, fifo_empty;
  logic          hs, redirect, redirect_bad, resp_keep, bypass;
  logic          fifo_push, fifo_pop, fifo_clr;
  fetch_entry_t  fifo_wdata, fifo_rdata;

  assign hs           = imem_req & imem_ready;
  assign redirect_bad = branch_taken && is_misaligned(pc_branch);
  assign redirect     = branch_taken && !redirect_bad && (state != ST_HALT);
  assign occupancy    = {1'b0, outstanding} + {1'b0, fifo_count};

  // A response is only kept when every request in flight belongs to the current path.
  assign resp_keep  = imem_rvalid && !pcq_empty && (state == ST_RUN) && (discard == '0)
                      && !redirect && !redirect_bad;
  assign bypass     = resp_keep && !id_stall && fifo_empty;
  assign fifo_push  = resp_keep && !bypass;
  assign fifo_pop   = !id_stall && !fifo_empty;
  assign fifo_clr   = redirect || redirect_bad;
  assign fifo_wdata = '{pc: pcq_head, instr: imem_rdata};

  // Request-side PC queue: its occupancy is the outstanding request count.
  elbeth_fetch_buffer #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .push    (hs),
    .wr_data (pc),
    .pop     (imem_rvalid),
    .rd_data (pcq_head),
    .full    (pcq_full),
    .empty   (pcq_empty),
    .count   (outstanding)
  );

  elbeth_fetch_buffer #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fetch_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr),
    .push    (fifo_push),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The redirecting cycle's own request and response are both counted as stale.
  assign discard_set = outstanding - CW'(imem_rvalid) + CW'(hs);

  always_comb begin
    discard_nxt = discard;
    if (redirect && state == ST_RUN)
      discard_nxt = discard_set;
    else if (imem_rvalid && discard != '0)
      discard_nxt = discard - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      discard <= '0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (redirect && discard_nxt != '0) state_nxt = ST_FLUSH;
      ST_FLUSH: if (discard_nxt == '0) state_nxt = ST_RUN;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RUN;
    endcase
    if (redirect_bad) state_nxt = ST_HALT;
  end

  always_comb begin
    imem_req = 1'b0;
    if (!rst && state == ST_RUN && occupancy < DEPTH_LIM && !pcq_full && !fifo_full)
      imem_req = 1'b1;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= pc_branch;
    else if (hs)
      pc <= pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst)
      fetch_misalign <= 1'b0;
    else if (redirect_bad)
      fetch_misalign <= 1'b1;
  end

  // Decode-facing output register; an empty buffer takes the response directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid       <= 1'b0;
      if_pc          <= RESET_PC;
      if_instruction <= NOP_INSTR;
    end else if (redirect || redirect_bad) begin
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
    end else if (!id_stall) begin
      if (!fifo_empty) begin
        if_valid       <= 1'b1;
        if_pc          <= fifo_rdata.pc;
        if_instruction <= fifo_rdata.instr;
      end else if (resp_keep) begin
        if_valid       <= 1'b1;
        if_pc          <= pcq_head;
        if_instruction <= imem_rdata;
      end else begin
        if_valid       <= 1'b0;
        if_instruction <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Bench for elbeth_fetch_unit: queue-based fetch model plus directed scenarios.
module tb_elbeth_fetch_unit;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, branch_taken, id_stall, imem_ready, imem_rvalid;
  logic [31:0] pc_branch, imem_rdata;
  logic        imem_req, if_valid, fetch_misalign;
  logic [31:0] imem_addr, if_pc, if_instruction;

  always #5 clk = ~clk;

  elbeth_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .pc_branch      (pc_branch),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .fetch_misalign (fetch_misalign)
  );

  int checks = 0;
  int errors = 0;

  // Memory: returns requests in order, one per cycle, at least one cycle later.
  logic [31:0] mem_q[$];
  bit          mem_hold;

  // Model: requests in flight (stale once a redirect passes them), responses not yet shown.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } flight_t;
  flight_t     flight[$];
  logic [63:0] pend[$];
  logic [31:0] m_pc, e_pc, e_instr;
  bit          e_valid, e_misalign, halted, live;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit exp_req();
    int stale_n = 0;
    foreach (flight[i]) if (flight[i].stale) stale_n++;
    return !rst && !halted && stale_n == 0 && (flight.size() + pend.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit er);
    bit      hs;
    flight_t f;
    f = '{addr: 32'h0, stale: 1'b1};
    if (rst) begin
      flight.delete(); pend.delete();
      m_pc = RST_PC; e_valid = 0; e_pc = RST_PC; e_instr = NOP;
      e_misalign = 0; halted = 0; live = 1;
      return;
    end
    if (!live) return;
    hs = er && imem_ready;
    if (imem_rvalid && flight.size() > 0) f = flight.pop_front();
    if (hs) flight.push_back('{addr: m_pc, stale: 1'b0});
    if (branch_taken && pc_branch[1:0] != 2'b00) begin
      halted = 1; e_misalign = 1; pend.delete(); e_valid = 0; e_instr = NOP;
      foreach (flight[i]) flight[i].stale = 1;
    end else if (branch_taken && !halted) begin
      foreach (flight[i]) flight[i].stale = 1;
      pend.delete(); e_valid = 0; e_instr = NOP; m_pc = pc_branch;
    end else begin
      if (hs) m_pc = m_pc + 32'd4;
      if (imem_rvalid && !f.stale && !halted) pend.push_back({f.addr, instr_of(f.addr)});
      if (!id_stall) begin
        if (pend.size() > 0) begin
          {e_pc, e_instr} = pend.pop_front();
          e_valid = 1;
        end else begin
          e_valid = 0;
          e_instr = NOP;
        end
      end
    end
  endtask

  // One clock: check outputs mid-cycle, advance model and memory, return just after the edge.
  task automatic tick();
    bit er;
    @(negedge clk);
    er = exp_req();
    if (live) begin
      chk("imem_req", imem_req, er);
      if (er) chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", if_valid, e_valid);
      if (e_valid) begin
        chk("if_pc", if_pc, e_pc);
        chk("if_instruction", if_instruction, e_instr);
      end else begin
        chk("if_instruction_nop", if_instruction, NOP);
      end
      chk("fetch_misalign", fetch_misalign, e_misalign);
    end
    if (rst) mem_q.delete();
    else if (imem_req && imem_ready) mem_q.push_back(imem_addr);
    model_edge(er);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (!rst && !mem_hold && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q.pop_front());
    end
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!if_valid && n < max) begin
      tick();
      n++;
    end
    if (!if_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: if_valid still %b after %0d cycles, expected 1", name, if_valid, max);
    end
  endtask

  task automatic redirect(input logic [31:0] target, input bit stall);
    branch_taken = 1'b1;
    pc_branch    = target;
    id_stall     = stall;
    tick();
    branch_taken = 1'b0;
    id_stall     = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; branch_taken = 1'b0; pc_branch = 32'h0; id_stall = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_hold = 1'b0; live = 1'b0;
    tick();
    tick();

    // 1) streaming after reset
    rst = 1'b0;
    #1;
    chk("t1_req_c0", imem_req, 1);
    chk("t1_addr_c0", imem_addr, 32'h0);
    chk("t1_valid_reset", if_valid, 0);
    chk("t1_pc_reset", if_pc, RST_PC);
    chk("t1_instr_reset", if_instruction, NOP);
    tick();
    chk("t1_addr_c1", imem_addr, 32'h4);
    tick();
    chk("t1_valid_c2", if_valid, 1);
    chk("t1_pc_c2", if_pc, 32'h0);
    chk("t1_instr_c2", if_instruction, instr_of(32'h0));
    repeat (6) tick();

    // 2) decode stall with the buffer filling up
    id_stall = 1'b1;
    tick();
    tick();
    chk("t2_req_full", imem_req, 0);
    tick();
    id_stall = 1'b0;
    repeat (8) tick();

    // 3) redirect with two requests outstanding
    mem_hold = 1'b1;
    repeat (4) tick();
    chk("t3_req_blocked", imem_req, 0);
    redirect(32'h100, 1'b0);
    chk("t3_flush_req", imem_req, 0);
    mem_hold = 1'b0;
    repeat (3) tick();
    chk("t3_req_resume", imem_req, 1);
    chk("t3_addr_resume", imem_addr, 32'h100);
    wait_valid("t3_wait", 10);
    chk("t3_pc", if_pc, 32'h100);
    chk("t3_instr", if_instruction, instr_of(32'h100));

    // 3b) second redirect while still flushing retargets only
    mem_hold = 1'b1;
    repeat (3) tick();
    redirect(32'h300, 1'b0);
    redirect(32'h340, 1'b0);
    mem_hold = 1'b0;
    wait_valid("t3b_wait", 10);
    chk("t3b_pc", if_pc, 32'h340);

    // 4) redirect coinciding with a response and an accepted request, decode stalled
    repeat (4) tick();
    redirect(32'h200, 1'b1);
    chk("t4_valid_forced", if_valid, 0);
    chk("t4_flush_req", imem_req, 0);
    wait_valid("t4_wait", 10);
    chk("t4_pc", if_pc, 32'h200);
    chk("t4_instr", if_instruction, instr_of(32'h200));
    repeat (3) tick();

    // 6) PC wraps modulo 2^32
    redirect(32'hFFFF_FFF8, 1'b0);
    n = 0;
    while (!(imem_req && imem_addr == 32'hFFFF_FFFC) && n < 10) begin
      tick();
      n++;
    end
    chk("t6_reach_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_req", imem_req, 1);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    repeat (5) tick();

    // 5) misaligned redirect halts until reset
    redirect(32'h102, 1'b0);
    chk("t5_misalign", fetch_misalign, 1);
    chk("t5_valid", if_valid, 0);
    chk("t5_req", imem_req, 0);
    redirect(32'h400, 1'b0);
    repeat (5) tick();
    chk("t5_req_halted", imem_req, 0);
    chk("t5_misalign_sticky", fetch_misalign, 1);
    rst = 1'b1;
    tick();
    tick();
    chk("t5_misalign_cleared", fetch_misalign, 0);
    rst = 1'b0;
    #1;
    chk("t5_restart_req", imem_req, 1);
    chk("t5_restart_addr", imem_addr, RST_PC);
    wait_valid("t5_wait", 10);
    chk("t5_restart_pc", if_pc, RST_PC);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
